// File: rtl/ap_unsi_div_4b_seq.sv
// Sequential radix-2 restoring unsigned divider: 2*DW-bit dividend / DW-bit divisor,
// one quotient bit per cycle, valid/ready handshake on both sides.
module ap_unsi_div_4b_seq #(
  parameter int unsigned DW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2*DW-1:0] dvd,
  input  logic [DW-1:0]   dvs,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [2*DW-1:0] quot,
  output logic [DW-1:0]   rem,
  output logic            dz
);

  localparam int unsigned QW = 2 * DW;
  localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [QW-1:0]   wq;
  logic [DW-1:0]   prem;
  logic [DW-1:0]   dvs_r;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last;
  logic [DW:0]     t;
  logic            ge;
  logic [DW-1:0]   diff;
  logic [DW-1:0]   prem_nxt;
  logic [QW-1:0]   wq_nxt;

  assign accept = in_vld && in_rdy;
  assign last   = (cnt == CW'(QW - 1));

  // prem stays below dvs, so its extra MSB is always zero and only t carries it;
  // the subtraction can therefore be done modulo 2^DW.
  always_comb begin
    t        = {prem, wq[QW-1]};
    ge       = (t >= {1'b0, dvs_r});
    diff     = t[DW-1:0] - dvs_r;
    prem_nxt = ge ? diff : t[DW-1:0];
    wq_nxt   = {wq[QW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (dvs == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = (state == IDLE);
    out_vld = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq    <= '0;
      prem  <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dvs != '0) begin
              wq    <= dvd;
              prem  <= '0;
              dvs_r <= dvs;
              cnt   <= '0;
            end else begin
              quot <= '1;
              rem  <= '0;
              dz   <= 1'b1;
            end
          end
        end
        BUSY: begin
          wq   <= wq_nxt;
          prem <= prem_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            quot <= wq_nxt;
            rem  <= prem_nxt;
            dz   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
